// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: word fetches from PC buffered in a DEPTH-entry FIFO,
// with flush redirect and discard of in-flight responses. `FETCH_BYPASS_EN adds empty-queue bypass.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif

module fetch_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          EXC_LEN   = `EXCEPTION_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [31:0]                  flush_pc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_instr_o,
    output logic [31:0]                  out_pc_o,
    output logic [EXC_LEN-1:0]           out_exc_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic [31:0]                  mem_addr_o,
    output logic                         mem_req_o,
    input  logic                         mem_ok_i,
    input  logic [31:0]                  mem_data_i,
    input  logic [EXC_LEN-1:0]           mem_exc_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [31:0]        pc_q    [DEPTH];
    logic [31:0]        pc_d    [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        instr_d [DEPTH];
    logic [EXC_LEN-1:0] exc_q   [DEPTH];
    logic [EXC_LEN-1:0] exc_d   [DEPTH];
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]      level_q, level_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic               req_q, req_d, discard_q, discard_d, halted_q, halted_d;

    logic empty, rsp, keep, bypass, push, pop;
    logic unused_flush_lsb;

    assign unused_flush_lsb = ^flush_pc_i[1:0];

    assign empty = (level_q == '0);
    assign rsp   = req_q && mem_ok_i;
    // A response is kept only if it was not made stale by an earlier or simultaneous flush.
    assign keep  = rsp && !discard_q && !flush_i;
`ifdef FETCH_BYPASS_EN
    assign bypass = empty && keep && out_ready_i;
`else
    assign bypass = 1'b0;
`endif
    assign push = keep && !bypass;
    assign pop  = !empty && out_ready_i && !flush_i;

    assign level_o    = level_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;

    always_comb begin
        out_valid_o = !empty;
        out_pc_o    = empty ? '0 : pc_q[head_q];
        out_instr_o = empty ? '0 : instr_q[head_q];
        out_exc_o   = empty ? '0 : exc_q[head_q];
        if (bypass) begin
            out_valid_o = 1'b1;
            out_pc_o    = fetch_pc_q;
            out_instr_o = mem_data_i;
            out_exc_o   = mem_exc_i;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        exc_d      = exc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        discard_d  = discard_q;
        halted_d   = halted_q;

        // Issue decisions use the current level, so a push landing this cycle is already counted.
        if (req_q) begin
            req_d = !mem_ok_i;
        end else if (!halted_q && (level_q < LW'(DEPTH)) && !flush_i) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
        end

        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            level_d    = '0;
            fetch_pc_d = {flush_pc_i[31:2], 2'b00};
            halted_d   = 1'b0;
            discard_d  = req_q && !mem_ok_i;
        end else begin
            if (rsp) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (mem_exc_i != '0) halted_d = 1'b1;
                end
            end
            if (push) begin
                pc_d[tail_q]    = fetch_pc_q;
                instr_d[tail_q] = mem_data_i;
                exc_d[tail_q]   = mem_exc_i;
                tail_d          = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            fetch_pc_q <= BOOT_ADDR;
            addr_q     <= BOOT_ADDR;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
        exc_q   <= exc_d;
    end
endmodule
